// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch sequencer between the program-counter block, instruction memory
// and the decode stage. Boots the pc, issues one fetch at a time, and holds the
// fetched instruction in a registered output slot. Branch redirects flush the slot
// and drop any fetch still in flight.
// Optional feature: define PC_CTRL_TRAP_EN to add the trap redirect ports. A trap
// has priority over a branch in the same cycle.
module pc_ctrl #(
    parameter logic [63:0] RESET_VEC = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_pc,
    output logic        o_pc_we,
    output logic [63:0] o_pc_wdata,
    output logic        o_pc_stall,
    input  logic        i_stall,
    input  logic        i_br_valid,
    input  logic [63:0] i_br_target,
`ifdef PC_CTRL_TRAP_EN
    input  logic        i_trap_valid,
    input  logic [63:0] i_trap_vec,
`endif
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [63:0] o_if_pc,
    output logic [31:0] o_if_instr
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        IDLE    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_r;
    logic [63:0] addr_r;
    logic        valid_r;
    logic [63:0] if_pc_r;
    logic [31:0] if_instr_r;

    logic        redir_req_s;
    logic [63:0] redir_tgt_s;
    logic        redirect_s;
    logic        pc_we_s;
    logic [63:0] pc_wdata_s;
    logic        pc_stall_s;
    logic [63:0] pc_next_s;

    // Select the redirect source; a trap wins over a branch.
    always_comb begin
        redir_req_s = 1'b0;
        redir_tgt_s = 64'h0;
`ifdef PC_CTRL_TRAP_EN
        if (i_trap_valid) begin
            redir_req_s = 1'b1;
            redir_tgt_s = i_trap_vec;
        end else if (i_br_valid) begin
            redir_req_s = 1'b1;
            redir_tgt_s = i_br_target;
        end else begin
            redir_req_s = 1'b0;
            redir_tgt_s = 64'h0;
        end
`else
        if (i_br_valid) begin
            redir_req_s = 1'b1;
            redir_tgt_s = i_br_target;
        end else begin
            redir_req_s = 1'b0;
            redir_tgt_s = 64'h0;
        end
`endif
    end

    // Redirects are ignored while the boot vector is being loaded.
    assign redirect_s = redir_req_s && (state_r != BOOT);

    // Drive the pc block: boot load, redirect load, or advance on an accepted fetch.
    always_comb begin
        pc_we_s    = 1'b0;
        pc_wdata_s = 64'h0;
        pc_stall_s = 1'b1;
        if (i_rst) begin
            pc_we_s    = 1'b0;
            pc_wdata_s = 64'h0;
            pc_stall_s = 1'b1;
        end else begin
            case (state_r)
                BOOT: begin
                    pc_we_s    = 1'b1;
                    pc_wdata_s = RESET_VEC;
                end
                REQ: begin
                    if (redirect_s) begin
                        pc_we_s    = 1'b1;
                        pc_wdata_s = redir_tgt_s;
                    end else if (i_imem_ack) begin
                        pc_stall_s = 1'b0;
                    end else begin
                        pc_stall_s = 1'b1;
                    end
                end
                IDLE, DISCARD: begin
                    if (redirect_s) begin
                        pc_we_s    = 1'b1;
                        pc_wdata_s = redir_tgt_s;
                    end else begin
                        pc_we_s    = 1'b0;
                    end
                end
                default: begin
                    pc_stall_s = 1'b1;
                end
            endcase
        end
    end

    // Value the pc will hold after this edge on every path that enters REQ
    // (the pc is never advancing on those paths), so the fetch address is ready
    // from a register on the first REQ cycle.
    assign pc_next_s = pc_we_s ? pc_wdata_s : i_pc;

    // Fetch state machine plus the registered fetch slot and memory address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= BOOT;
            addr_r     <= 64'h0;
            valid_r    <= 1'b0;
            if_pc_r    <= 64'h0;
            if_instr_r <= 32'h0;
        end else begin
            // Decode consumes the slot; the cases below override on flush or refill.
            if (valid_r && !i_stall) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                BOOT: begin
                    state_r <= REQ;
                    addr_r  <= pc_next_s;
                end
                REQ: begin
                    if (redirect_s) begin
                        valid_r <= 1'b0;
                        if (i_imem_ack) begin
                            state_r <= REQ;
                            addr_r  <= pc_next_s;
                        end else begin
                            state_r <= DISCARD;
                        end
                    end else if (i_imem_ack) begin
                        valid_r    <= 1'b1;
                        if_pc_r    <= addr_r;
                        if_instr_r <= i_imem_rdata;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= REQ;
                    end
                end
                IDLE: begin
                    if (redirect_s) begin
                        valid_r <= 1'b0;
                        state_r <= REQ;
                        addr_r  <= pc_next_s;
                    end else if (!valid_r || !i_stall) begin
                        state_r <= REQ;
                        addr_r  <= pc_next_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect_s) begin
                        valid_r <= 1'b0;
                    end
                    if (i_imem_ack) begin
                        state_r <= REQ;
                        addr_r  <= pc_next_s;
                    end else begin
                        state_r <= DISCARD;
                    end
                end
                default: begin
                    state_r <= BOOT;
                end
            endcase
        end
    end

    // Outputs read as their reset values for as long as reset is held.
    assign o_pc_we     = pc_we_s;
    assign o_pc_wdata  = pc_wdata_s;
    assign o_pc_stall  = pc_stall_s;
    assign o_imem_req  = !i_rst && ((state_r == REQ) || (state_r == DISCARD));
    assign o_imem_addr = i_rst ? 64'h0 : addr_r;
    assign o_if_valid  = !i_rst && valid_r;
    assign o_if_pc     = i_rst ? 64'h0 : if_pc_r;
    assign o_if_instr  = i_rst ? 32'h0 : if_instr_r;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 64'h0, SHALL be the boot address loaded into the program counter after reset.
REQ-002 i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 i_pc  in  64  SHALL carry the current program counter value from the pc block.
REQ-005 o_pc_we  out  1, o_pc_wdata  out  64, o_pc_stall  out  1  SHALL drive the pc block's write-enable, load value and stall inputs; write-enable takes priority over stall.
REQ-006 i_stall  in  1  SHALL be the decode-stage stall; the fetched instruction is consumed on any cycle with o_if_valid=1 and i_stall=0.
REQ-007 i_br_valid  in  1, i_br_target  in  64  SHALL request a branch or jump redirect.
REQ-008 o_imem_req  out  1, o_imem_addr  out  64, i_imem_ack  in  1, i_imem_rdata  in  32  SHALL form the instruction-memory request/acknowledge port.
REQ-009 o_if_valid  out  1, o_if_pc  out  64, o_if_instr  out  32  SHALL form the registered fetch output slot.
REQ-010 i_trap_valid  in  1, i_trap_vec  in  64  SHALL request a trap redirect; these ports exist only under PC_CTRL_TRAP_EN.

Function
REQ-011 The FSM SHALL have states BOOT, REQ, IDLE and DISCARD.
REQ-012 BOOT: o_pc_we=1 and o_pc_wdata=RESET_VEC for one cycle; next state is REQ.
REQ-013 On entry to REQ, o_imem_addr SHALL latch i_pc; in REQ, o_imem_req=1 and o_imem_addr SHALL stay stable until i_imem_ack.
REQ-014 REQ with ack and no redirect: latch o_if_instr=i_imem_rdata, o_if_pc=o_imem_addr and o_if_valid=1; drive o_pc_stall=0 so the pc advances by 4; next state is IDLE.
REQ-015 o_pc_stall SHALL be 1 on every cycle except the case in REQ-014.
REQ-016 IDLE: o_imem_req=0; move to REQ when o_if_valid=0 or i_stall=0, otherwise stay in IDLE.
REQ-017 o_if_valid SHALL clear on consumption unless the same edge latches a new instruction.
REQ-018 Redirect: o_pc_we=1 for one cycle, o_pc_wdata = the selected target, and o_if_valid cleared (flush) on the same edge.
REQ-019 Redirect priority: trap over branch. Redirects during BOOT SHALL be ignored.
REQ-020 Redirect in REQ without ack: next state is DISCARD. Redirect in REQ with ack: the data is dropped and the next state is REQ.
REQ-021 DISCARD: o_imem_req remains 1 on the old address; on ack the data is dropped and the next state is REQ.
REQ-022 A further redirect in DISCARD SHALL update the pc; the state stays DISCARD unless ack is present that cycle.
REQ-023 i_imem_ack SHALL be ignored in BOOT and IDLE.
REQ-024 Throughput is at most one instruction per 2 cycles, including the IDLE bubble; a single-cycle memory gives ack on the req cycle.

Reset
REQ-025 While i_rst=1: state BOOT, o_if_valid=0, o_if_pc=0, o_if_instr=0, o_imem_req=0, o_imem_addr=0, o_pc_we=0, o_pc_wdata=0, o_pc_stall=1.
REQ-026 Reset mid-fetch SHALL abandon the outstanding request; instruction memory is reset by the same i_rst.

Configuration
REQ-027 With PC_CTRL_TRAP_EN defined, the trap ports and trap priority SHALL be present. Without it, the trap ports are absent and only branch redirects exist.

Verification
REQ-028 RESET_VEC=0x1000, ack on the req cycle, i_stall=0 -> o_if_pc sequence 0x1000, 0x1004, 0x1008, with o_if_valid high every 2nd cycle.
REQ-029 i_stall=1 held 5 cycles after the first fetch -> o_if_valid and o_if_pc=0x1000 hold, no o_imem_req, pc stays 0x1004; fetch resumes 1 cycle after release.
REQ-030 Branch to 0x2000 while REQ waits 3 cycles for ack -> the pc is written to 0x2000 at once, the late 0x1004 data is dropped, and the next o_imem_addr is 0x2000.
REQ-031 Branch to 0x2000 and trap to 0x80 in the same cycle (PC_CTRL_TRAP_EN) -> o_pc_wdata=0x80 and no 0x2000 fetch.
REQ-032 i_rst asserted in DISCARD -> BOOT next cycle, then the pc is loaded with 0x1000 and o_if_valid=0 until a fresh ack.
